serial_adder: RTL and testbench

Bit-serial N-bit adder built around the existing 1-bit full adder `yAdder1`. It consumes operands in parallel on a start pulse and processes one bit position per clock, LSB first, through a single `yAdder1` instance with a registered carry. It then presents the registered sum, carry-out and signed overflow with a done level. It sits downstream of the operand registers and upstream of the datapath result bus, trading area for latency.

---
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit position per clock, LSB first, through a
// single yAdder1 with a registered carry. Result, carry-out and overflow are held with done.

module yAdder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic z,
    output logic cout
);
    assign z    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            last_bit;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    count;

    logic             add_z;
    logic             add_cout;

    yAdder1 u_add (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .z    (add_z),
        .cout (add_cout)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            s_sr     <= '0;
            carry    <= 1'b0;
            count    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                count <= '0;
            end else if (state == RUN) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                s_sr  <= {add_z, s_sr[WIDTH-1:1]};
                carry <= add_cout;
                count <= count + 1'b1;
                // On the MSB cycle the carry register is exactly the carry into the MSB.
                if (last_bit) begin
                    sum      <= {add_z, s_sr[WIDTH-1:1]};
                    cout     <= add_cout;
                    overflow <= carry ^ add_cout;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and an exhaustive
// WIDTH=2 sweep, against an arithmetic reference model.

module tb_serial_adder;
    logic       clk;
    logic       reset;

    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    logic       start2, cin2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;

    int n_cmp;
    int n_bad;
    logic [9:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: {overflow, cout, sum} from plain integer addition and sign rules.
    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] full;
        logic       ov;
        full = {1'b0, x} + {1'b0, y} + {8'd0, c};
        ov   = (x[7] == y[7]) && (full[7] != x[7]);
        return {ov, full};
    endfunction

    function automatic logic [3:0] model2(input int x, input int y, input int c);
        int  full;
        int  sx, sy, ss;
        logic ov;
        full = x + y + c;
        sx = (x >= 2) ? x - 4 : x;
        sy = (y >= 2) ? y - 4 : y;
        ss = sx + sy + c;
        ov = (ss > 1) || (ss < -2);
        return {ov, 3'(full)};
    endfunction

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input int poke_at);
        logic [7:0] prev_sum;
        logic [9:0] expv;
        int cyc;
        prev_sum = sum8;
        expv = model8(ta, tb, tc);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        check("busy_after_start", 32'(busy8), 32'd1);
        check("done_after_start", 32'(done8), 32'd0);
        check("sum_held_in_run", 32'(sum8), 32'(prev_sum));
        cyc = 1;
        while (!done8 && cyc < 20) begin
            start8 = (cyc == poke_at);
            @(negedge clk);
            start8 = 1'b0;
            cyc++;
        end
        check("latency8", 32'(cyc), 32'd9);
        check("sum8", 32'(sum8), 32'(expv[7:0]));
        check("cout8", 32'(cout8), 32'(expv[8]));
        check("ovf8", 32'(ovf8), 32'(expv[9]));
        check("busy_at_done", 32'(busy8), 32'd0);
    endtask

    task automatic op2(input int x, input int y, input int c);
        logic [3:0] expv;
        int cyc;
        expv = model2(x, y, c);
        a2 = 2'(x); b2 = 2'(y); cin2 = 1'(c); start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
        cyc = 1;
        while (!done2 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("latency2", 32'(cyc), 32'd3);
        check("sum_cout2", 32'({cout2, sum2}), 32'(expv[2:0]));
        check("ovf2", 32'(ovf2), 32'(expv[3]));
    endtask

    initial begin
        logic [9:0] expv;
        int cyc;
        n_cmp = 0; n_bad = 0;
        reset = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        check("rst_w2", 32'({busy2, done2, sum2, cout2, ovf2}), 32'd0);

        // Directed cases
        op8(8'h5A, 8'h3C, 1'b0, -1);
        check("5a3c_sum_const", 32'(sum8), 32'h96);
        check("5a3c_ovf_const", 32'(ovf8), 32'd1);
        op8(8'hFF, 8'h01, 1'b0, -1);
        op8(8'h80, 8'h80, 1'b0, -1);
        op8(8'h00, 8'h00, 1'b1, -1);
        check("cin_only_sum", 32'(sum8), 32'h01);

        // Done is a level while idle in DONE
        repeat (3) @(negedge clk);
        check("done_level", 32'({busy8, done8}), 32'b01);

        // Start during RUN is ignored and nothing is queued
        op8(8'h12, 8'h34, 1'b0, 3);
        repeat (4) begin
            @(negedge clk);
            check("no_second_op", 32'({busy8, done8}), 32'b01);
        end
        check("poke_sum_kept", 32'(sum8), 32'h46);

        // Reset mid-RUN, with a start asserted alongside it
        a8 = 8'hC3; b8 = 8'h77; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; start8 = 1'b1;
        @(negedge clk);
        reset = 1'b0; start8 = 1'b0;
        check("midrst_outs", 32'({busy8, done8, sum8, cout8, ovf8}), 32'd0);
        @(negedge clk);
        check("midrst_start_dropped", 32'({busy8, done8}), 32'd0);
        op8(8'hC3, 8'h77, 1'b1, -1);

        // Random operations
        for (int i = 0; i < 16; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), -1);

        // Start held high: one result every WIDTH+1 cycles
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        exp_q.push_back(model8(a8, b8, cin8));
        start8 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done8 && cyc < 20);
            check("held_period", 32'(cyc), 32'd9);
            expv = exp_q.pop_front();
            check("held_result", 32'({ovf8, cout8, sum8}), 32'(expv));
            if (k == 5) begin
                start8 = 1'b0;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                exp_q.push_back(model8(a8, b8, cin8));
            end
        end
        @(negedge clk);
        check("held_stop", 32'({busy8, done8}), 32'b01);

        // Exhaustive WIDTH=2 sweep
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++)
                    op2(x, y, c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL timeout: simulation exceeded its time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end
endmodule
